// File: rtl/reg_bypass_unit.sv
// Operand bypass network with load-use and long-latency scoreboard hazard detection.
// Forwarding and stall are same-cycle combinational; scoreboard and stall counter update on the next edge.
module reg_bypass_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NPORT  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT*ADDR_W-1:0] rd_addr,
    input  logic [NPORT*DATA_W-1:0] rd_regval,
    input  logic [ADDR_W-1:0]       ex_addr,
    input  logic [DATA_W-1:0]       ex_val,
    input  logic [1:0]              ex_type,
    input  logic [ADDR_W-1:0]       mm_addr,
    input  logic [DATA_W-1:0]       mm_val,
    input  logic [1:0]              mm_type,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_val,
    input  logic                    wb_we,
    input  logic                    lu_issue,
    input  logic [ADDR_W-1:0]       lu_addr,
    input  logic                    lu_done,
    output logic [NPORT*DATA_W-1:0] rd_val,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic                    lu_busy
);

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_R2R  = 2'b01;
    localparam logic [1:0] T_M2R  = 2'b10;
    localparam logic [1:0] T_R2M  = 2'b11;

    logic              sb_valid;
    logic [ADDR_W-1:0] sb_addr;
    logic [NPORT-1:0]  port_stall;

    // Producer qualifiers shared by every read port.
    logic ex_fwd_ok;
    logic mm_fwd_ok;
    logic ex_is_load;

    assign ex_fwd_ok  = (ex_type == T_R2R);
    assign mm_fwd_ok  = (mm_type == T_R2R) || (mm_type == T_M2R);
    assign ex_is_load = (ex_type == T_M2R);

    generate
        for (genvar i = 0; i < NPORT; i++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] regval;
            logic [DATA_W-1:0] fwd;
            logic              nz;
            logic              ex_hit;
            logic              mm_hit;
            logic              wb_hit;

            assign addr   = rd_addr[i*ADDR_W +: ADDR_W];
            assign regval = rd_regval[i*DATA_W +: DATA_W];
            assign nz     = (addr != '0);
            assign ex_hit = nz && (addr == ex_addr) && ex_fwd_ok;
            assign mm_hit = nz && (addr == mm_addr) && mm_fwd_ok;
            assign wb_hit = nz && (addr == wb_addr) && wb_we;

            // Youngest producer wins; register zero is hardwired.
            always_comb begin
                fwd = regval;
                if (!nz)         fwd = '0;
                else if (ex_hit) fwd = ex_val;
                else if (mm_hit) fwd = mm_val;
                else if (wb_hit) fwd = wb_val;
            end

            assign rd_val[i*DATA_W +: DATA_W] = fwd;

            assign port_stall[i] = nz &&
                                   (((addr == ex_addr) && ex_is_load) ||
                                    (sb_valid && (addr == sb_addr)));
        end
    endgenerate

    assign stall   = |port_stall;
    assign lu_busy = sb_valid;

    // Issue takes precedence over done so back-to-back long ops never drop a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= 1'b0;
            sb_addr  <= '0;
        end else if (lu_issue) begin
            sb_valid <= (lu_addr != '0);
            sb_addr  <= lu_addr;
        end else if (lu_done) begin
            sb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_bypass_unit.sv
// Randomized and directed checks of reg_bypass_unit against a spec-level model.
module tb_reg_bypass_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_regval;
    logic [AW-1:0]     ex_addr, mm_addr, wb_addr, lu_addr;
    logic [DW-1:0]     ex_val, mm_val, wb_val;
    logic [1:0]        ex_type, mm_type;
    logic              wb_we, lu_issue, lu_done;
    logic [NP*DW-1:0]  rd_val;
    logic              stall;
    logic [CW-1:0]     stall_cnt;
    logic              lu_busy;

    int checks = 0;
    int errors = 0;

    bit          m_busy;
    logic [AW-1:0] m_addr;
    int          m_cnt;

    reg_bypass_unit #(.DATA_W(DW), .ADDR_W(AW), .NPORT(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_regval(rd_regval),
        .ex_addr(ex_addr), .ex_val(ex_val), .ex_type(ex_type),
        .mm_addr(mm_addr), .mm_val(mm_val), .mm_type(mm_type),
        .wb_addr(wb_addr), .wb_val(wb_val), .wb_we(wb_we),
        .lu_issue(lu_issue), .lu_addr(lu_addr), .lu_done(lu_done),
        .rd_val(rd_val), .stall(stall), .stall_cnt(stall_cnt), .lu_busy(lu_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int p);
        return rd_addr[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input int p);
        logic [AW-1:0] a;
        a = port_addr(p);
        if (a == 0) return '0;
        if (a == ex_addr && ex_type == 2'b01) return ex_val;
        if (a == mm_addr && (mm_type == 2'b01 || mm_type == 2'b10)) return mm_val;
        if (wb_we && a == wb_addr) return wb_val;
        return rd_regval[p*DW +: DW];
    endfunction

    function automatic bit exp_stall();
        bit s;
        s = 0;
        for (int p = 0; p < NP; p++) begin
            if (port_addr(p) != 0) begin
                if (port_addr(p) == ex_addr && ex_type == 2'b10) s = 1;
                if (m_busy && port_addr(p) == m_addr) s = 1;
            end
        end
        return s;
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic tick(input string tag);
        bit s;
        if (!rst_n) begin
            m_busy = 0; m_addr = '0; m_cnt = 0;
        end
        #1;
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s_rdval%0d", tag, p), 64'(rd_val[p*DW +: DW]), 64'(exp_fwd(p)));
        chk({tag, "_stall"}, 64'(stall), 64'(exp_stall()));
        chk({tag, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
        chk({tag, "_busy"}, 64'(lu_busy), 64'(m_busy));
        @(posedge clk);
        if (rst_n) begin
            s = exp_stall();
            if (s && m_cnt < CMAX) m_cnt++;
            if (lu_issue) begin
                m_busy = (lu_addr != 0);
                m_addr = lu_addr;
            end else if (lu_done) begin
                m_busy = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rd_addr = '0; rd_regval = {$urandom, $urandom};
        ex_addr = '0; ex_val = '0; ex_type = 2'b00;
        mm_addr = '0; mm_val = '0; mm_type = 2'b00;
        wb_addr = '0; wb_val = '0; wb_we = 1'b0;
        lu_issue = 1'b0; lu_addr = '0; lu_done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_busy = 0; m_addr = '0; m_cnt = 0;
        #2;
        chk("reset_cnt", 64'(stall_cnt), 64'd0);
        chk("reset_busy", 64'(lu_busy), 64'd0);
        @(negedge clk);
        do_reset();

        // Youngest R2R producer wins over MM.
        rd_addr[0 +: AW] = 5'd3;
        ex_addr = 5'd3; ex_type = 2'b01; ex_val = 32'h11;
        mm_addr = 5'd3; mm_type = 2'b01; mm_val = 32'h22;
        #1;
        chk("s32_p0", 64'(rd_val[0 +: DW]), 64'h11);
        chk("s32_stall", 64'(stall), 64'd0);
        tick("s32");

        // Load-use stall, then MM load forwarding.
        do_reset();
        rd_addr[AW +: AW] = 5'd7;
        ex_addr = 5'd7; ex_type = 2'b10;
        #1;
        chk("s33_stall1", 64'(stall), 64'd1);
        tick("s33a");
        ex_type = 2'b00;
        mm_addr = 5'd7; mm_type = 2'b10; mm_val = 32'hAB;
        #1;
        chk("s33_stall2", 64'(stall), 64'd0);
        chk("s33_p1", 64'(rd_val[DW +: DW]), 64'hAB);
        chk("s33_cnt", 64'(stall_cnt), 64'd1);
        tick("s33b");

        // Register zero never forwards.
        idle();
        ex_addr = '0; ex_type = 2'b01; ex_val = 32'hDEAD;
        mm_addr = '0; mm_type = 2'b10; mm_val = 32'hBEEF;
        wb_addr = '0; wb_we = 1'b1; wb_val = 32'hCAFE;
        rd_regval[0 +: DW] = 32'h1234;
        #1;
        chk("s34_p0", 64'(rd_val[0 +: DW]), 64'd0);
        chk("s34_stall", 64'(stall), 64'd0);
        tick("s34");

        // Long-latency scoreboard stall.
        do_reset();
        lu_issue = 1'b1; lu_addr = 5'd9;
        tick("s35_iss");
        lu_issue = 1'b0;
        rd_addr[0 +: AW] = 5'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s35_stall", 64'(stall), 64'd1);
            tick("s35_wait");
        end
        lu_done = 1'b1;
        #1;
        chk("s35_done_stall", 64'(stall), 64'd1);
        tick("s35_done");
        lu_done = 1'b0;
        wb_addr = 5'd9; wb_we = 1'b1; wb_val = 32'h5;
        #1;
        chk("s35_stall_end", 64'(stall), 64'd0);
        chk("s35_p0", 64'(rd_val[0 +: DW]), 64'h5);
        chk("s35_cnt", 64'(stall_cnt), 64'd5);
        tick("s35_wb");

        // Saturation and asynchronous reset mid long-latency op.
        do_reset();
        rd_addr[0 +: AW] = 5'd2;
        ex_addr = 5'd2; ex_type = 2'b10;
        lu_issue = 1'b1; lu_addr = 5'd3;
        for (int i = 0; i < 20; i++) begin
            tick("s36_sat");
            lu_issue = 1'b0;
        end
        #1;
        chk("s36_cnt_sat", 64'(stall_cnt), 64'd15);
        chk("s36_busy", 64'(lu_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s36_async_cnt", 64'(stall_cnt), 64'd0);
        chk("s36_async_busy", 64'(lu_busy), 64'd0);
        @(negedge clk);
        tick("s36_inrst");
        rst_n = 1'b1;
        idle();
        tick("s36_post");

        // Zero-address issue never marks busy.
        lu_issue = 1'b1; lu_addr = '0;
        tick("z_iss");
        lu_issue = 1'b0;
        #1;
        chk("z_busy", 64'(lu_busy), 64'd0);
        tick("z_after");

        // Issue wins over done in the same cycle.
        lu_issue = 1'b1; lu_addr = 5'd6;
        tick("s37_first");
        lu_done = 1'b1; lu_addr = 5'd4;
        tick("s37_both");
        lu_issue = 1'b0; lu_done = 1'b0;
        rd_addr[0 +: AW] = 5'd4;
        #1;
        chk("s37_busy", 64'(lu_busy), 64'd1);
        chk("s37_new_stall", 64'(stall), 64'd1);
        tick("s37_new");
        rd_addr[0 +: AW] = 5'd6;
        #1;
        chk("s37_old_stall", 64'(stall), 64'd0);
        tick("s37_old");
        lu_done = 1'b1;
        tick("s37_clr");

        // Random traffic with small address range to provoke matches.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            for (int p = 0; p < NP; p++) begin
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3));
                rd_regval[p*DW +: DW] = $urandom;
            end
            ex_addr = AW'($urandom_range(0, 3)); ex_val = $urandom; ex_type = 2'($urandom);
            mm_addr = AW'($urandom_range(0, 3)); mm_val = $urandom; mm_type = 2'($urandom);
            wb_addr = AW'($urandom_range(0, 3)); wb_val = $urandom; wb_we = 1'($urandom);
            lu_done = (m_busy && $urandom_range(0, 3) == 0);
            lu_issue = ((!m_busy || lu_done) && $urandom_range(0, 4) == 0);
            lu_addr = AW'($urandom_range(0, 3));
            tick("rnd");
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bypass_unit.md
REG_BYPASS_UNIT -- requirements
Module: reg_bypass_unit

Parameters
REQ-001 The block SHALL provide parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL provide parameter ADDR_W, default 5, meaning register address width.
REQ-003 The block SHALL provide parameter NPORT, default 2, meaning the number of independent ID read ports.
REQ-004 The block SHALL provide parameter CNT_W, default 16, meaning the width of the stall statistics counter.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have port rd_addr, input, NPORT*ADDR_W bits, packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port rd_regval, input, NPORT*DATA_W bits, register-file values for each port, packed the same way.
REQ-009 The block SHALL have ports ex_addr (ADDR_W), ex_val (DATA_W) and ex_type (2), all inputs, for the EX-stage producer.
REQ-010 The block SHALL have ports mm_addr, mm_val and mm_type, all inputs, for the MM-stage producer, with the same widths as EX.
REQ-011 The block SHALL have ports wb_addr (ADDR_W), wb_val (DATA_W) and wb_we (1), all inputs, for the WB-stage writer.
REQ-012 The block SHALL have port lu_issue, input, 1 bit, which starts a long-latency op (MUL/DIV) writing lu_addr (ADDR_W, input).
REQ-013 The block SHALL have port lu_done, input, 1 bit, which signals completion of the pending long-latency op.
REQ-014 The block SHALL have port rd_val, output, NPORT*DATA_W bits, the forwarded operand values.
REQ-015 The block SHALL have port stall, output, 1 bit, the combinational hold request to IF/ID.
REQ-016 The block SHALL have port stall_cnt, output, CNT_W bits, a saturating count of stalled cycles.
REQ-017 The block SHALL have port lu_busy, output, 1 bit, asserted while a long-latency write is pending.

Function
REQ-018 Type encoding SHALL be 2'b00 NONE, 2'b01 R2R (ALU result), 2'b10 M2R (load), 2'b11 R2M (store, no register write).
REQ-019 Each port SHALL forward per this priority:
- address 0: output 0
- else EX match with type R2R: ex_val
- else MM match with type R2R or M2R: mm_val
- else WB match with wb_we=1: wb_val
- else: rd_regval
REQ-020 A match SHALL require address equality and a non-zero address; a non-writing type SHALL never match.
REQ-021 Load-use hazard: any port with nonzero address equal to ex_addr while ex_type=M2R SHALL assert stall in the same cycle.
REQ-022 Scoreboard state SHALL be sb_valid (1 bit) and sb_addr (ADDR_W); lu_busy SHALL equal sb_valid.
REQ-023 lu_issue=1 SHALL set sb_valid=1 and load sb_addr=lu_addr at the next edge; lu_issue with lu_addr=0 SHALL leave sb_valid=0.
REQ-024 lu_done=1 SHALL clear sb_valid at the next edge; if lu_done and lu_issue occur in the same cycle, the issue SHALL win (valid stays 1, new address loaded).
REQ-025 Any port reading a nonzero address equal to sb_addr while sb_valid=1 SHALL assert stall, including in the cycle lu_done is high (the value arrives via WB next).
REQ-026 stall SHALL be the OR of all load-use and scoreboard conditions across ports; it SHALL be purely combinational and SHALL not depend on stall history.
REQ-027 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL hold at 2^CNT_W-1 (no wrap).
REQ-028 rd_val SHALL be valid even while stall=1; consumers ignore it.

Reset
REQ-029 While rst_n=0, sb_valid, sb_addr, stall_cnt and lu_busy SHALL be 0 immediately, independent of clk.
REQ-030 Reset asserted mid long-latency op SHALL discard the pending entry; the first edge after release SHALL behave as from a clean state.
REQ-031 rd_val and stall SHALL remain combinational functions of inputs and state during reset.

Verification
REQ-032 Scenario: rd_addr port0=3, ex_addr=3 R2R ex_val=0x11, mm_addr=3 R2R mm_val=0x22 -> rd_val port0=0x11, stall=0.
REQ-033 Scenario: rd_addr port1=7, ex_addr=7 M2R -> stall=1; next cycle ex_type=NONE, mm_addr=7 M2R mm_val=0xAB -> stall=0, port1=0xAB, stall_cnt=1.
REQ-034 Scenario: port0 addr=0 while EX/MM/WB all target 0 with nonzero values -> rd_val port0=0, stall=0.
REQ-035 Scenario: lu_issue lu_addr=9; port0 reads 9 for 4 cycles -> stall=1 each cycle; lu_done pulse then WB wb_addr=9 we=1 val=0x5 -> stall=0, port0=0x5, stall_cnt=5.
REQ-036 Scenario: CNT_W=4, stall held 20 cycles -> stall_cnt=15; rst_n pulsed low mid-run -> stall_cnt=0 and lu_busy=0 asynchronously.
REQ-037 Scenario: lu_done and lu_issue (lu_addr=4) in the same cycle -> lu_busy stays 1, reading 4 stalls, reading the old address does not.
